control_unit: RTL and testbench

//  Hardwired Moore sequencer for the phase-2 bus datapath. Runs fetch (T0-T2), decodes IRVal, then

---
 rtl/control_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer (fetch T0-T2, execute T3-T5) for the phase-2 bus datapath.
// Define CU_STEP_EN to add a 'step' input that holds the FSM idle in T0 until step=1.
module control_unit #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int SIG_COUNT = 13,
    parameter int MEM_WAIT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CU_STEP_EN
    input  logic                 step,
`endif
    input  logic [BITS-1:0]      IRVal,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 HILOin,
    output logic                 MDRin,
    output logic                 OUTPUTin,
    output logic                 INPUTout,
    output logic                 MDRout,
    output logic                 HILOout,
    output logic                 RZout,
    output logic                 PCout,
    output logic                 BAout,
    output logic                 Read,
    output logic                 Write,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 IncPC,
    output logic                 run,
    output logic                 illegal
);
    localparam logic [2:0] S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
                           S_T4 = 3'd4, S_T5 = 3'd5, S_HALT = 3'd6;

    localparam logic [4:0] OP_LD  = 5'b00000, OP_ST  = 5'b00010, OP_ADD  = 5'b00011,
                           OP_SUB = 5'b00100, OP_SHR = 5'b00101, OP_SHL  = 5'b00110,
                           OP_ROR = 5'b00111, OP_ROL = 5'b01000, OP_AND  = 5'b01001,
                           OP_OR  = 5'b01010, OP_MUL = 5'b01110, OP_DIV  = 5'b01111,
                           OP_NEG = 5'b10000, OP_NOT = 5'b10001, OP_MFHI = 5'b10100,
                           OP_IN  = 5'b10110, OP_OUT = 5'b10111, OP_NOP  = 5'b11010,
                           OP_HALT = 5'b11011;

    localparam int A_ADD = 0, A_SUB = 1, A_MUL = 2, A_DIV = 3, A_SHR = 4, A_SHL = 5,
                   A_ROR = 6, A_ROL = 7, A_AND = 8, A_OR = 9, A_NEG = 10, A_NOT = 11,
                   A_INC = 12;

    logic [2:0] state_reg, state_next;
    logic [3:0] wait_reg, wait_next;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic [REGISTERS-1:0] ra_hot, rb_hot, rc_hot;
    logic [SIG_COUNT-1:0] op_alu, alu_op;
    logic is_alu3, is_muldiv, is_unary, is_ld, is_st, is_long, is_access, hold, step_ok;
    logic unused_ir;

    assign op = IRVal[31:27];
    assign ra = IRVal[26:23];
    assign rb = IRVal[22:19];
    assign rc = IRVal[18:15];
    assign unused_ir = ^IRVal[14:0];

`ifdef CU_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < REGISTERS; gi++) begin : g_gpr_dec
            assign ra_hot[gi] = (int'(ra) % REGISTERS) == gi;
            assign rb_hot[gi] = (int'(rb) % REGISTERS) == gi;
            assign rc_hot[gi] = (int'(rc) % REGISTERS) == gi;
        end
    endgenerate

    assign is_alu3   = (op >= OP_ADD) && (op <= OP_OR);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
    assign is_ld     = (op == OP_LD);
    assign is_st     = (op == OP_ST);
    assign is_long   = is_alu3 || is_muldiv || is_ld || is_st;

    // Memory access steps stretch by MEM_WAIT cycles; the counter is reloaded whenever not holding.
    assign is_access = (state_reg == S_T1) || ((state_reg == S_T4) && is_ld) ||
                       ((state_reg == S_T5) && is_st);
    assign hold      = is_access && (wait_reg != 4'd0);

    always_comb begin
        op_alu = '0;
        case (op)
            OP_ADD:  op_alu[A_ADD] = 1'b1;
            OP_SUB:  op_alu[A_SUB] = 1'b1;
            OP_MUL:  op_alu[A_MUL] = 1'b1;
            OP_DIV:  op_alu[A_DIV] = 1'b1;
            OP_SHR:  op_alu[A_SHR] = 1'b1;
            OP_SHL:  op_alu[A_SHL] = 1'b1;
            OP_ROR:  op_alu[A_ROR] = 1'b1;
            OP_ROL:  op_alu[A_ROL] = 1'b1;
            OP_AND:  op_alu[A_AND] = 1'b1;
            OP_OR:   op_alu[A_OR]  = 1'b1;
            OP_NEG:  op_alu[A_NEG] = 1'b1;
            OP_NOT:  op_alu[A_NOT] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = 4'(MEM_WAIT);
        if (hold) begin
            wait_next = wait_reg - 4'd1;
        end else begin
            case (state_reg)
                S_T0:    if (step_ok) state_next = S_T1;
                S_T1:    state_next = S_T2;
                S_T2:    state_next = S_T3;
                S_T3:    state_next = (op == OP_HALT) ? S_HALT :
                                      (is_long || is_unary) ? S_T4 : S_T0;
                S_T4:    state_next = is_long ? S_T5 : S_T0;
                S_T5:    state_next = S_T0;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_T0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_T0;
            wait_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
        end
    end

    // Strobes are a pure decode of {state, IRVal}, forced low while reset is asserted.
    always_comb begin
        PCin = 1'b0; IRin = 1'b0; RYin = 1'b0; RZin = 1'b0; MARin = 1'b0; HILOin = 1'b0;
        MDRin = 1'b0; OUTPUTin = 1'b0; INPUTout = 1'b0; MDRout = 1'b0; HILOout = 1'b0;
        RZout = 1'b0; PCout = 1'b0; BAout = 1'b0; Read = 1'b0; Write = 1'b0;
        GPRin = '0; GPRout = '0; alu_op = '0; illegal = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_T0: if (step_ok) begin
                    PCout = 1'b1; MARin = 1'b1; RZin = 1'b1; alu_op[A_INC] = 1'b1;
                end
                S_T1: begin RZout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
                S_T3: begin
                    if (is_alu3) begin
                        GPRout = rb_hot; RYin = 1'b1;
                    end else if (is_muldiv) begin
                        GPRout = ra_hot; RYin = 1'b1;
                    end else if (is_unary) begin
                        GPRout = rb_hot; alu_op = op_alu; RZin = 1'b1;
                    end else if (is_ld || is_st) begin
                        GPRout = rb_hot; BAout = (rb == 4'd0); MARin = 1'b1;
                    end else begin
                        case (op)
                            OP_MFHI:        begin HILOout = 1'b1; GPRin = ra_hot; end
                            OP_IN:          begin INPUTout = 1'b1; GPRin = ra_hot; end
                            OP_OUT:         begin GPRout = ra_hot; OUTPUTin = 1'b1; end
                            OP_NOP, OP_HALT: ;
                            default:        illegal = 1'b1;
                        endcase
                    end
                end
                S_T4: begin
                    if (is_alu3) begin
                        GPRout = rc_hot; alu_op = op_alu; RZin = 1'b1;
                    end else if (is_muldiv) begin
                        GPRout = rb_hot; alu_op = op_alu; RZin = 1'b1;
                    end else if (is_unary) begin
                        RZout = 1'b1; GPRin = ra_hot;
                    end else if (is_ld) begin
                        Read = 1'b1; MDRin = 1'b1;
                    end else if (is_st) begin
                        GPRout = ra_hot; MDRin = 1'b1;
                    end
                end
                S_T5: begin
                    if (is_alu3) begin
                        RZout = 1'b1; GPRin = ra_hot;
                    end else if (is_muldiv) begin
                        RZout = 1'b1; HILOin = 1'b1;
                    end else if (is_ld) begin
                        MDRout = 1'b1; GPRin = ra_hot;
                    end else if (is_st) begin
                        Write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ADD    = alu_op[A_ADD];
    assign SUB    = alu_op[A_SUB];
    assign MUL    = alu_op[A_MUL];
    assign DIV    = alu_op[A_DIV];
    assign SHR    = alu_op[A_SHR];
    assign SHL    = alu_op[A_SHL];
    assign ROR    = alu_op[A_ROR];
    assign ROL    = alu_op[A_ROL];
    assign AND    = alu_op[A_AND];
    assign OR     = alu_op[A_OR];
    assign NEGATE = alu_op[A_NEG];
    assign NOT    = alu_op[A_NOT];
    assign IncPC  = alu_op[A_INC];

    assign run = !reset && (state_reg != S_HALT);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: two instances (MEM_WAIT 0 and 3) checked cycle by cycle against a
// per-instruction strobe-sequence model built from the instruction table.
module tb_control_unit;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst;
    logic [31:0]   ir [NI];
`ifdef CU_STEP_EN
    logic [NI-1:0] step;
    bit            drop_step = 1'b0;
`endif

    typedef struct packed {
        logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin;
        logic INPUTout, MDRout, HILOout, RZout, PCout, BAout, Read, Write;
        logic [15:0] gin;
        logic [15:0] gout;
        logic [12:0] alu;   // {IncPC,NOT,NEGATE,OR,AND,ROL,ROR,SHL,SHR,DIV,MUL,SUB,ADD}
        logic run, illegal;
    } obs_t;

    obs_t obs [NI];
    obs_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin;
            logic INPUTout, MDRout, HILOout, RZout, PCout, BAout, Read, Write;
            logic [15:0] GPRin, GPRout;
            logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
            logic run, illegal;

            control_unit #(.BITS(32), .REGISTERS(16), .SIG_COUNT(13), .MEM_WAIT(gi * 3)) dut (
                .clk(clk), .reset(rst[gi]),
`ifdef CU_STEP_EN
                .step(step[gi]),
`endif
                .IRVal(ir[gi]),
                .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
                .HILOin(HILOin), .MDRin(MDRin), .OUTPUTin(OUTPUTin), .INPUTout(INPUTout),
                .MDRout(MDRout), .HILOout(HILOout), .RZout(RZout), .PCout(PCout),
                .BAout(BAout), .Read(Read), .Write(Write), .GPRin(GPRin), .GPRout(GPRout),
                .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
                .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
                .IncPC(IncPC), .run(run), .illegal(illegal)
            );

            assign obs[gi] = {PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin,
                              INPUTout, MDRout, HILOout, RZout, PCout, BAout, Read, Write,
                              GPRin, GPRout,
                              IncPC, NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD,
                              run, illegal};
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t idle();
        obs_t s = '0;
        s.run = 1'b1;
        return s;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] r);
        return 16'd1 << r;
    endfunction

    function automatic int alu_idx(input logic [4:0] op);
        case (op)
            5'd3: return 0;   5'd4: return 1;   5'd14: return 2;  5'd15: return 3;
            5'd5: return 4;   5'd6: return 5;   5'd7: return 6;   5'd8: return 7;
            5'd9: return 8;   5'd10: return 9;  5'd16: return 10; 5'd17: return 11;
            default: return 0;
        endcase
    endfunction

    // Expected strobe set for every cycle of one instruction, T0 through its last step.
    function automatic void build(input int mw, input logic [31:0] instr);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        obs_t s;
        op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
        exp_q.delete();
        s = idle(); s.PCout = 1; s.MARin = 1; s.RZin = 1; s.alu[12] = 1; exp_q.push_back(s);
        s = idle(); s.RZout = 1; s.PCin = 1; s.Read = 1; s.MDRin = 1;
        repeat (mw + 1) exp_q.push_back(s);
        s = idle(); s.MDRout = 1; s.IRin = 1; exp_q.push_back(s);
        if (op inside {[5'd3:5'd10]}) begin
            s = idle(); s.gout = oh(rb); s.RYin = 1; exp_q.push_back(s);
            s = idle(); s.gout = oh(rc); s.alu[alu_idx(op)] = 1; s.RZin = 1; exp_q.push_back(s);
            s = idle(); s.RZout = 1; s.gin = oh(ra); exp_q.push_back(s);
        end else if (op == 5'd14 || op == 5'd15) begin
            s = idle(); s.gout = oh(ra); s.RYin = 1; exp_q.push_back(s);
            s = idle(); s.gout = oh(rb); s.alu[alu_idx(op)] = 1; s.RZin = 1; exp_q.push_back(s);
            s = idle(); s.RZout = 1; s.HILOin = 1; exp_q.push_back(s);
        end else if (op == 5'd16 || op == 5'd17) begin
            s = idle(); s.gout = oh(rb); s.alu[alu_idx(op)] = 1; s.RZin = 1; exp_q.push_back(s);
            s = idle(); s.RZout = 1; s.gin = oh(ra); exp_q.push_back(s);
        end else if (op == 5'd0 || op == 5'd2) begin
            s = idle(); s.gout = oh(rb); s.BAout = (rb == 4'd0); s.MARin = 1; exp_q.push_back(s);
            if (op == 5'd0) begin
                s = idle(); s.Read = 1; s.MDRin = 1; repeat (mw + 1) exp_q.push_back(s);
                s = idle(); s.MDRout = 1; s.gin = oh(ra); exp_q.push_back(s);
            end else begin
                s = idle(); s.gout = oh(ra); s.MDRin = 1; exp_q.push_back(s);
                s = idle(); s.Write = 1; repeat (mw + 1) exp_q.push_back(s);
            end
        end else begin
            s = idle();
            case (op)
                5'd20: begin s.HILOout = 1; s.gin = oh(ra); end
                5'd22: begin s.INPUTout = 1; s.gin = oh(ra); end
                5'd23: begin s.gout = oh(ra); s.OUTPUTin = 1; end
                5'd26, 5'd27: ;
                default: s.illegal = 1;
            endcase
            exp_q.push_back(s);
        end
    endfunction

    // Called at a falling edge with instance k in T0; returns at the falling edge after the last step.
    task automatic run_instr(input int k, input logic [31:0] instr, input int abort_at);
        build(k * 3, instr);
        ir[k] = instr;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) begin
                rst[k] = 1'b1;
                #1 check($sformatf("k%0d rst_mid", k), obs[k], '0);
                @(negedge clk);
                rst[k] = 1'b0;
                $display("instr k=%0d ir=%h aborted by reset at cycle %0d", k, instr, i);
                return;
            end
            #1 check($sformatf("k%0d ir=%h cyc%0d", k, instr, i), obs[k], exp_q[i]);
            @(negedge clk);
`ifdef CU_STEP_EN
            if (i == 0 && drop_step) step[k] = 1'b0;
`endif
        end
        $display("instr k=%0d ir=%h cycles=%0d", k, instr, exp_q.size());
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        @(negedge clk);
        #1 check($sformatf("k%0d reset", k), obs[k], '0);
        @(negedge clk);
        rst[k] = 1'b0;
        $display("reset k=%0d", k);
    endtask

    logic [4:0]  valid_ops [18] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                    5'd10, 5'd14, 5'd15, 5'd16, 5'd17, 5'd20, 5'd22, 5'd23, 5'd26};
    logic [4:0]  rop;
    logic [31:0] rinstr;

    initial begin
        rst   = '1;
        ir[0] = '0;
        ir[1] = '0;
`ifdef CU_STEP_EN
        step = '1;
`endif
        for (int k = 0; k < NI; k++) begin
            do_reset(k);
            run_instr(k, 32'h19890000, -1);          // ADD r3,r1,r2
            run_instr(k, 32'h19890000, k * 3 + 4);   // reset during T4
            run_instr(k, 32'h18C40000, -1);
            run_instr(k, 32'h02800000, -1);          // LD r5,(r0)
            run_instr(k, 32'h10000000 | 32'h01800000 | 32'h00080000, -1);  // ST r3,(r1)
            run_instr(k, 32'h70900000, -1);          // MUL r1,r2
            run_instr(k, 32'h78900000, -1);          // DIV r1,r2
            run_instr(k, 32'hF8000000, -1);          // undefined opcode
            run_instr(k, 32'h00000000 | 32'h04000000, -1);
            for (int n = 0; n < 40; n++) begin
                rop = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 3) != 0) rop = valid_ops[$urandom_range(0, 17)];
                if (rop == 5'd27) rop = 5'd26;
                rinstr = {rop, 27'($urandom)};
                run_instr(k, rinstr, -1);
            end
`ifdef CU_STEP_EN
            step[k] = 1'b0;
            repeat (20) begin
                #1 check($sformatf("k%0d step_idle", k), obs[k], idle());
                @(negedge clk);
            end
            drop_step = 1'b1;
            step[k] = 1'b1;
            run_instr(k, 32'h19890000, -1);
            drop_step = 1'b0;
            repeat (3) begin
                #1 check($sformatf("k%0d step_after", k), obs[k], idle());
                @(negedge clk);
            end
            step[k] = 1'b1;
`endif
            run_instr(k, 32'hD8000000, -1);          // HALT
            repeat (100) begin
                #1 check($sformatf("k%0d halt", k), obs[k], '0);
                @(negedge clk);
            end
            $display("halt k=%0d held 100 cycles", k);
            do_reset(k);
            run_instr(k, 32'h19890000, -1);
            rst[k] = 1'b1;
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
